// File: rtl/perceptron_pkg.sv
// Purpose : shared fixed-point types and helpers for the perceptron datapath
//           (Q15.16 sign-magnitude words, MAC sequencer states, format conversions).
// Ports   : none (package); imported by the MAC sequencer, the multiplier and neuron-level blocks.
package perceptron_pkg;

  localparam int FX_SIGN = 1;
  localparam int FX_Q_M  = 15;
  localparam int FX_Q_N  = 16;
  localparam int W       = FX_SIGN + FX_Q_M + FX_Q_N;

  // Helpers work at a fixed wide width so callers with any guard size can
  // size-cast the result down to their own accumulator width.
  localparam int WIDE_W  = 64;

  typedef logic [W-1:0]               fixed_t;
  typedef logic signed [WIDE_W-1:0]   wide_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SAT   = 3'd3,
    DONE  = 3'd4
  } mac_state_t;

  typedef struct packed {
    logic                sat;
    logic signed [W-1:0] val;
  } sat_res_t;

  // Largest representable sign-magnitude magnitude: 2^(W-1)-1.
  localparam wide_t SAT_MAX = wide_t'((64'sd1 <<< (W - 1)) - 64'sd1);

  // Sign-magnitude to two's complement; -0 negates to 0.
  function automatic wide_t sm2tc(input fixed_t v);
    wide_t mag;
    mag = wide_t'({{(WIDE_W - W + 1){1'b0}}, v[W-2:0]});
    return v[W-1] ? -mag : mag;
  endfunction

  // Clamp to the symmetric sign-magnitude range +/-(2^(W-1)-1).
  function automatic sat_res_t sat_clamp(input wide_t a);
    sat_res_t r;
    wide_t    neg_max;
    neg_max = -SAT_MAX;
    r.sat   = 1'b0;
    r.val   = a[W-1:0];
    if (a > SAT_MAX) begin
      r.sat = 1'b1;
      r.val = SAT_MAX[W-1:0];
    end else if (a < neg_max) begin
      r.sat = 1'b1;
      r.val = neg_max[W-1:0];
    end
    return r;
  endfunction

  // Two's complement to sign-magnitude; zero always comes out as +0.
  // Input must already be clamped, so -2^(W-1) never reaches here.
  function automatic fixed_t tc2sm(input logic signed [W-1:0] v);
    logic signed [W-1:0] mag;
    mag = -v;
    if (v < 0) begin
      return {1'b1, mag[W-2:0]};
    end
    return {1'b0, v[W-2:0]};
  endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// Purpose : combinational sign-magnitude Q15.16 multiply.
// Latency : 0 cycles (pure combinational). Backpressure: none.
// Ports   : a_in, b_in operands; p_out product (magnitude floored, bits above W-2 dropped).
module fixed_point_multiplier
  import perceptron_pkg::*;
(
  input  fixed_t a_in,
  input  fixed_t b_in,
  output fixed_t p_out
);

  localparam int MW = W - 1;

  logic [2*MW-1:0] a_ext;
  logic [2*MW-1:0] b_ext;
  logic [2*MW-1:0] mag_full;
  logic            unused_mag_bits;

  assign a_ext    = {{MW{1'b0}}, a_in[W-2:0]};
  assign b_ext    = {{MW{1'b0}}, b_in[W-2:0]};
  assign mag_full = a_ext * b_ext;

  // Dropping the low Q_N bits floors the magnitude; overflow above the
  // word is discarded silently, callers size their operands accordingly.
  assign p_out = {a_in[W-1] ^ b_in[W-1], mag_full[FX_Q_N +: MW]};

  assign unused_mag_bits = ^{mag_full[2*MW-1:FX_Q_N+MW], mag_full[FX_Q_N-1:0]};

endmodule

// File: rtl/perceptron_mac_sequencer.sv
// Purpose : y = bias + sum(x[i]*w[i]) using one time-shared multiplier, saturating SM result.
// Latency : y_valid_out rises N_INPUTS+2 edges after the accepting edge.
// Backpressure: ready_out only in IDLE; result held in DONE until y_ready_in.
// Ports   : clk_in/rst_n_in (async active-low); start_in/ready_out request handshake;
//           x_vec_in/w_vec_in/bias_in operands sampled on accept;
//           y_valid_out/y_ready_in result handshake; y_out result; sat_out clamp flag.
module perceptron_mac_sequencer
  import perceptron_pkg::*;
#(
  parameter int SIGN      = 1,
  parameter int Q_M       = 15,
  parameter int Q_N       = 16,
  parameter int N_INPUTS  = 4,
  parameter int ACC_GUARD = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  output logic                  ready_out,
  input  logic [N_INPUTS*W-1:0] x_vec_in,
  input  logic [N_INPUTS*W-1:0] w_vec_in,
  input  logic [W-1:0]          bias_in,
  output logic                  y_valid_out,
  input  logic                  y_ready_in,
  output logic [W-1:0]          y_out,
  output logic                  sat_out
);

  localparam int ACC_W = W + ACC_GUARD;
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  if (SIGN != 1 || SIGN + Q_M + Q_N != W) begin : g_fmt_chk
    $error("perceptron_mac_sequencer: word format must match perceptron_pkg");
  end
  if (N_INPUTS < 1) begin : g_n_chk
    $error("perceptron_mac_sequencer: N_INPUTS must be >= 1");
  end
  if (ACC_GUARD < $clog2(N_INPUTS + 1) + 1) begin : g_guard_chk
    $error("perceptron_mac_sequencer: ACC_GUARD too small for N_INPUTS");
  end
  if (ACC_W > WIDE_W) begin : g_wide_chk
    $error("perceptron_mac_sequencer: accumulator wider than package helpers");
  end

  mac_state_t               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [N_INPUTS*W-1:0]    x_vec_q, x_vec_d;
  logic [N_INPUTS*W-1:0]    w_vec_q, w_vec_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  fixed_t                   prod_q, prod_d;
  fixed_t                   y_q, y_d;
  logic                     sat_q, sat_d;

  fixed_t                   x_sel;
  fixed_t                   w_sel;
  fixed_t                   mult_p;
  sat_res_t                 clamp;
  logic                     accept;

  assign accept = start_in && (state_q == IDLE);
  assign x_sel  = x_vec_q[idx_q*W +: W];
  assign w_sel  = w_vec_q[idx_q*W +: W];
  assign clamp  = sat_clamp(wide_t'(acc_q));

  fixed_point_multiplier u_mult (
    .a_in  (x_sel),
    .b_in  (w_sel),
    .p_out (mult_p)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)            state_d = RUN;
      RUN:     if (idx_q == IDX_LAST) state_d = DRAIN;
      DRAIN:                          state_d = SAT;
      SAT:                            state_d = DONE;
      DONE:    if (y_ready_in)        state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    idx_d   = idx_q;
    x_vec_d = x_vec_q;
    w_vec_d = w_vec_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    y_d     = y_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_vec_d = x_vec_in;
          w_vec_d = w_vec_in;
          acc_d   = ACC_W'(sm2tc(bias_in));
          idx_d   = '0;
        end
      end
      RUN: begin
        prod_d = mult_p;
        idx_d  = idx_q + IDX_W'(1);
        // Accumulator trails the multiplier by one edge: on idx 0 prod_q
        // still holds a stale product, so nothing is added yet.
        if (idx_q != '0) begin
          acc_d = acc_q + ACC_W'(sm2tc(prod_q));
        end
      end
      DRAIN: begin
        acc_d = acc_q + ACC_W'(sm2tc(prod_q));
      end
      SAT: begin
        y_d   = tc2sm(clamp.val);
        sat_d = clamp.sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx_q   <= '0;
      x_vec_q <= '0;
      w_vec_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      x_vec_q <= x_vec_d;
      w_vec_q <= w_vec_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign ready_out   = (state_q == IDLE);
  assign y_valid_out = (state_q == DONE);
  assign y_out       = y_q;
  assign sat_out     = sat_q;

endmodule
